// File: rtl/cmd_decoder_mc.sv
// Multi-channel command decoder: buffers command words in a small FIFO and decodes one per cycle
// into per-channel power state, DAC amounts and one-cycle strobes, rejecting illegal commands.
module cmd_decoder_mc #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned AMOUNT_WIDTH = 8,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CH_W         = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned AMOUNT_MODE  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic                           hold,
    output logic [NUM_CH-1:0]              power_on,
    output logic [NUM_CH-1:0]              increase,
    output logic [NUM_CH-1:0]              decrease,
    output logic [NUM_CH-1:0]              send,
    output logic [NUM_CH-1:0]              receive,
    output logic [NUM_CH*AMOUNT_WIDTH-1:0] amount,
    output logic                           cmd_done,
    output logic [CH_W-1:0]                cmd_ch,
    output logic                           err,
    output logic [1:0]                     err_code,
    output logic [7:0]                     err_count,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned AW   = AMOUNT_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]       level_q;
    logic                  push, pop;

    // s_ready depends only on occupancy, so a full FIFO never accepts even when popping
    assign s_ready    = (level_q != LvlW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign pop        = (level_q != '0) && !hold;
    assign fifo_level = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      level_q <= level_q + LvlW'(1);
            else if (pop && !push) level_q <= level_q - LvlW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    logic [DATA_WIDTH-1:0] word;
    logic                  f_on, f_off, f_inc, f_dec, f_rcv, f_snd;
    logic [CH_W-1:0]       ch;
    logic [AW-1:0]         field, cur_amt, new_amt;
    logic [AW:0]           sum, diff;
    logic [1:0]            code;
    logic                  legal, rej;

    assign word  = mem_q[rd_ptr_q];
    assign f_on  = word[0];
    assign f_off = word[1];
    assign f_inc = word[2];
    assign f_dec = word[3];
    assign f_rcv = word[4];
    assign f_snd = word[5];
    assign ch    = word[6 +: CH_W];
    assign field = word[DATA_WIDTH-1 -: AW];

    always_comb begin
        code = 2'd0;
        if (f_on && f_off)           code = 2'd1;
        else if (f_inc && f_dec)     code = 2'd2;
        else if (32'(ch) >= NUM_CH)  code = 2'd3;
    end

    assign legal = pop && (code == 2'd0);
    assign rej   = pop && (code != 2'd0);

    always_comb begin
        cur_amt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == CH_W'(c)) cur_amt = amount[c*AW +: AW];
        end
    end

    // One extra bit catches overflow on add and borrow on subtract before clamping
    assign sum  = {1'b0, cur_amt} + {1'b0, field};
    assign diff = {1'b0, cur_amt} - {1'b0, field};

    always_comb begin
        new_amt = cur_amt;
        if (AMOUNT_MODE == 0)  new_amt = field;
        else if (f_inc)        new_amt = sum[AW] ? '1 : sum[AW-1:0];
        else if (f_dec)        new_amt = diff[AW] ? '0 : diff[AW-1:0];
    end

    logic [NUM_CH-1:0]    power_d, inc_d, dec_d, send_d, recv_d;
    logic [NUM_CH*AW-1:0] amount_d;
    logic [1:0]           code_d;
    logic [7:0]           cnt_d;
    logic [CH_W-1:0]      ch_d;

    always_comb begin
        power_d  = power_on;
        amount_d = amount;
        inc_d    = '0;
        dec_d    = '0;
        send_d   = '0;
        recv_d   = '0;
        code_d   = rej ? code : err_code;
        cnt_d    = (rej && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
        ch_d     = pop ? ch : cmd_ch;
        for (int c = 0; c < NUM_CH; c++) begin
            if (legal && ch == CH_W'(c)) begin
                if (f_on)       power_d[c] = 1'b1;
                else if (f_off) power_d[c] = 1'b0;
                inc_d[c]  = f_inc;
                dec_d[c]  = f_dec;
                send_d[c] = f_snd;
                recv_d[c] = f_rcv;
                amount_d[c*AW +: AW] = new_amt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            power_on  <= '0;
            increase  <= '0;
            decrease  <= '0;
            send      <= '0;
            receive   <= '0;
            amount    <= '0;
            cmd_done  <= 1'b0;
            cmd_ch    <= '0;
            err       <= 1'b0;
            err_code  <= '0;
            err_count <= '0;
        end else begin
            power_on  <= power_d;
            increase  <= inc_d;
            decrease  <= dec_d;
            send      <= send_d;
            receive   <= recv_d;
            amount    <= amount_d;
            cmd_done  <= legal;
            cmd_ch    <= ch_d;
            err       <= rej;
            err_code  <= code_d;
            err_count <= cnt_d;
        end
    end
endmodule

// File: tb/tb_cmd_decoder_mc.sv
// Bench for cmd_decoder_mc: two configurations (4 ch absolute, 3 ch relative) driven in parallel,
// checked every cycle against a queue-based model plus directed literal expectations.
module tb_cmd_decoder_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        hold = 1'b0;

    always #5 clk = ~clk;

    logic       a_ready, a_done, a_err, b_ready, b_done, b_err;
    logic [3:0] a_pw, a_inc, a_dec, a_send, a_recv;
    logic [2:0] b_pw, b_inc, b_dec, b_send, b_recv;
    logic [31:0] a_amt;
    logic [23:0] b_amt;
    logic [1:0] a_ch, a_code, b_ch, b_code;
    logic [7:0] a_cnt, b_cnt;
    logic [2:0] a_lvl, b_lvl;

    cmd_decoder_mc #(.NUM_CH(4), .AMOUNT_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(a_ready),
        .hold(hold), .power_on(a_pw), .increase(a_inc), .decrease(a_dec), .send(a_send),
        .receive(a_recv), .amount(a_amt), .cmd_done(a_done), .cmd_ch(a_ch), .err(a_err),
        .err_code(a_code), .err_count(a_cnt), .fifo_level(a_lvl)
    );

    cmd_decoder_mc #(.NUM_CH(3), .AMOUNT_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(b_ready),
        .hold(hold), .power_on(b_pw), .increase(b_inc), .decrease(b_dec), .send(b_send),
        .receive(b_recv), .amount(b_amt), .cmd_done(b_done), .cmd_ch(b_ch), .err(b_err),
        .err_code(b_code), .err_count(b_cnt), .fifo_level(b_lvl)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the FIFO is a queue; index 0 = 4 ch absolute, index 1 = 3 ch relative
    logic [31:0] q[$];
    bit   [3:0]  m_pw[2], m_inc[2], m_dec[2], m_snd[2], m_rcv[2];
    int          m_amt[2][4];
    bit          m_done[2], m_err[2];
    int          m_code[2], m_cnt[2], m_ch[2];

    task automatic model_dec(int k, logic [31:0] w);
        int  nch, ch, fld;
        bit  on, off, inc, dec;
        nch = (k == 0) ? 4 : 3;
        ch  = int'(w[7:6]);
        fld = int'(w[31:24]);
        on = w[0]; off = w[1]; inc = w[2]; dec = w[3];
        m_ch[k] = ch;
        if ((on && off) || (inc && dec) || ch >= nch) begin
            m_err[k]  = 1'b1;
            m_code[k] = (on && off) ? 1 : (inc && dec) ? 2 : 3;
            if (m_cnt[k] < 255) m_cnt[k]++;
        end else begin
            m_done[k] = 1'b1;
            if (on)  m_pw[k][ch] = 1'b1;
            if (off) m_pw[k][ch] = 1'b0;
            m_inc[k][ch] = inc;
            m_dec[k][ch] = dec;
            m_rcv[k][ch] = w[4];
            m_snd[k][ch] = w[5];
            if (k == 0)   m_amt[k][ch] = fld;
            else if (inc) m_amt[k][ch] = (m_amt[k][ch] + fld > 255) ? 255 : m_amt[k][ch] + fld;
            else if (dec) m_amt[k][ch] = (m_amt[k][ch] - fld < 0) ? 0 : m_amt[k][ch] - fld;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] w;
        bit          do_pop, do_push;
        if (!rst_n) begin
            q.delete();
            for (int k = 0; k < 2; k++) begin
                m_pw[k] = '0; m_inc[k] = '0; m_dec[k] = '0; m_snd[k] = '0; m_rcv[k] = '0;
                m_done[k] = 0; m_err[k] = 0; m_code[k] = 0; m_cnt[k] = 0; m_ch[k] = 0;
                for (int c = 0; c < 4; c++) m_amt[k][c] = 0;
            end
        end else begin
            do_push = s_valid && (q.size() < 4);
            do_pop  = (q.size() > 0) && !hold;
            w = '0;
            if (do_pop) w = q.pop_front();
            if (do_push) q.push_back(s_data);
            for (int k = 0; k < 2; k++) begin
                m_inc[k] = '0; m_dec[k] = '0; m_snd[k] = '0; m_rcv[k] = '0;
                m_done[k] = 0; m_err[k] = 0;
                if (do_pop) model_dec(k, w);
            end
        end
    end

    task automatic cmp_dut(int k, logic [31:0] rdy, lvl, pw, inc, dec, snd, rcv, amt,
                           done, ch, er, code, cnt);
        string p;
        int    nch;
        p   = (k == 0) ? "a." : "b.";
        nch = (k == 0) ? 4 : 3;
        chk({p, "s_ready"}, rdy, 32'(q.size() < 4));
        chk({p, "fifo_level"}, lvl, q.size());
        chk({p, "power_on"}, pw, 32'(m_pw[k]));
        chk({p, "increase"}, inc, 32'(m_inc[k]));
        chk({p, "decrease"}, dec, 32'(m_dec[k]));
        chk({p, "send"}, snd, 32'(m_snd[k]));
        chk({p, "receive"}, rcv, 32'(m_rcv[k]));
        chk({p, "cmd_done"}, done, 32'(m_done[k]));
        chk({p, "cmd_ch"}, ch, m_ch[k]);
        chk({p, "err"}, er, 32'(m_err[k]));
        chk({p, "err_code"}, code, m_code[k]);
        chk({p, "err_count"}, cnt, m_cnt[k]);
        for (int c = 0; c < nch; c++)
            chk($sformatf("%samount[%0d]", p, c), (amt >> (8 * c)) & 32'hFF, m_amt[k][c]);
    endtask

    bit run_cmp = 1'b0;
    always @(negedge clk) begin
        if (run_cmp) begin
            cmp_dut(0, a_ready, a_lvl, a_pw, a_inc, a_dec, a_send, a_recv, a_amt, a_done,
                    a_ch, a_err, a_code, a_cnt);
            cmp_dut(1, b_ready, b_lvl, b_pw, b_inc, b_dec, b_send, b_recv, b_amt, b_done,
                    b_ch, b_err, b_code, b_cnt);
        end
    end

    // Leaves the bench at the negedge after the decode edge, where outputs are visible
    task automatic cmd(logic [31:0] w);
        @(negedge clk);
        s_data  = w;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
    endtask

    int pulses_a, pulses_b;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset a.s_ready", a_ready, 1);
        chk("reset a.power_on", a_pw, 0);
        chk("reset a.amount", a_amt, 0);
        chk("reset a.err_count", a_cnt, 0);
        chk("reset a.fifo_level", a_lvl, 0);
        run_cmp = 1'b1;
        #2 rst_n = 1'b1;

        cmd(32'h0000_0045);
        chk("t1 a.power_on", a_pw, 4'b0010);
        chk("t1 a.cmd_done", a_done, 1);
        chk("t1 a.cmd_ch", a_ch, 1);
        chk("t1 a.err", a_err, 0);

        cmd(32'hFA00_0004);
        chk("rel b.amount0 load", b_amt[7:0], 250);
        cmd(32'h0A00_0004);
        chk("rel b.amount0 sat", b_amt[7:0], 255);
        chk("rel a.amount0 abs", a_amt[7:0], 8'h0A);
        cmd(32'h1400_0008);
        chk("rel b.amount0 dec", b_amt[7:0], 235);
        cmd(32'hFF00_0008);
        chk("rel b.amount0 floor", b_amt[7:0], 0);
        chk("rel a.amount0 abs2", a_amt[7:0], 8'hFF);

        @(negedge clk);
        hold = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h0000_0001;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            s_data = (i == 4) ? 32'h0000_0002 : (32'h0000_0001 | (32'(i) << 6));
        end
        chk("hold a.s_ready full", a_ready, 0);
        @(negedge clk);
        s_valid = 1'b0;
        chk("hold a.fifo_level", a_lvl, 4);
        hold = 1'b0;
        pulses_a = 0;
        pulses_b = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) chk("hold a.s_ready after pop", a_ready, 1);
            pulses_a += int'(a_done);
            pulses_b += int'(b_done);
        end
        chk("hold a.done pulses", pulses_a, 4);
        chk("hold b.done pulses", pulses_b, 3);
        chk("hold a.power_on", a_pw, 4'b1111);

        cmd(32'h0000_0003);
        chk("e1 a.err", a_err, 1);
        chk("e1 a.err_code", a_code, 1);
        cmd(32'h0000_000C);
        chk("e2 a.err_code", a_code, 2);
        chk("e2 a.err_count", a_cnt, 2);
        cmd(32'h0000_00C1);
        chk("e3 b.err_code", b_code, 3);
        chk("e3 b.err_count", b_cnt, 4);
        chk("e3 b.power_on", b_pw, 3'b111);
        chk("e3 a.cmd_done", a_done, 1);

        @(negedge clk);
        s_data = 32'h0000_0003;
        s_valid = 1'b1;
        repeat (260) @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat a.err_count", a_cnt, 255);
        chk("sat b.err_count", b_cnt, 255);

        cmd(32'h0000_00B0);
        chk("sr a.send", a_send, 4'b0100);
        chk("sr a.receive", a_recv, 4'b0100);
        chk("sr b.send", b_send, 3'b100);
        @(negedge clk);
        chk("sr a.send after", a_send, 0);
        chk("sr a.receive after", a_recv, 0);

        for (int c = 0; c < 4; c++) cmd(32'h0000_0001 | (32'(c) << 6));
        chk("rst a.power_on before", a_pw, 4'b1111);
        @(negedge clk);
        hold = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h0000_0002;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        chk("rst a.fifo_level queued", a_lvl, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst a.power_on", a_pw, 0);
        chk("rst a.fifo_level", a_lvl, 0);
        chk("rst a.amount", a_amt, 0);
        chk("rst a.err_count", a_cnt, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        hold = 1'b0;
        pulses_a = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pulses_a += int'(a_done);
        end
        chk("rst no stale cmd_done", pulses_a, 0);

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cmd_decoder_mc.md
Name: cmd_decoder_mc

Overview:
- Multi-channel successor to the single-word command decoder between the PS-side AXI register interface and the per-transducer drive/DAC logic.
- Accepts command words over a valid/ready handshake and buffers them in a small FIFO.
- Decodes one command per cycle into per-channel power state, saturating DAC amount registers, and one-cycle strobes.
- Rejects and counts illegal commands.

Parameters:
- DATA_WIDTH, 32, command word width; must be >= 6 + CH_W + AMOUNT_WIDTH.
- AMOUNT_WIDTH, 8, width of each channel's DAC amount.
- NUM_CH, 4, number of transducer channels (1..16).
- CH_W, 2, channel index field width; must satisfy 2**CH_W >= NUM_CH.
- FIFO_DEPTH, 4, command FIFO depth; power of 2, >= 2.
- AMOUNT_MODE, 0, 0 = absolute (amount field loaded), 1 = relative (increase/decrease add/subtract amount field, saturating).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- s_data  in  DATA_WIDTH  command word
- s_valid  in  1  command word valid
- s_ready  out  1  FIFO can accept (= !full)
- hold  in  1  stall decode stage; FIFO keeps filling
- power_on  out  NUM_CH  per-channel on level
- increase  out  NUM_CH  one-cycle increase strobe, per channel
- decrease  out  NUM_CH  one-cycle decrease strobe, per channel
- send  out  NUM_CH  one-cycle send strobe, per channel
- receive  out  NUM_CH  one-cycle receive strobe, per channel
- amount  out  NUM_CH*AMOUNT_WIDTH  per-channel DAC amount; channel c at [c*AMOUNT_WIDTH +: AMOUNT_WIDTH]
- cmd_done  out  1  one-cycle pulse: a legal command was applied
- cmd_ch  out  CH_W  channel of last decoded command (legal or not)
- err  out  1  one-cycle pulse: a command was rejected
- err_code  out  2  cause of last rejection; holds until next rejection
- err_count  out  8  count of rejected commands, saturates at 255
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk) forces:
  - FIFO empty, s_ready=1.
  - power_on, increase, decrease, send, receive, amount, cmd_done, err, err_code, err_count, cmd_ch all 0.
- Reset mid-operation flushes all queued commands; nothing in flight survives.
- Word fields:
  - Flags: bit0 on, bit1 off, bit2 inc, bit3 dec, bit4 receive, bit5 send.
  - Channel: bits [6 +: CH_W].
  - Amount: bits [DATA_WIDTH-1 -: AMOUNT_WIDTH].
  - All other bits are ignored.
- Push: on an edge with s_valid && s_ready. When full, s_ready=0 and there is no same-cycle pass-through, even if a pop occurs.
- Pop/decode: on any edge where the FIFO is non-empty and hold=0, exactly one entry is popped and decoded.
- Outputs register on that same edge, so latency from accepting edge to outputs is 1 cycle when the FIFO is empty and hold=0.
- Simultaneous push and pop leaves fifo_level unchanged.
- Rejection (checked in priority order; state unchanged, err=1, cmd_done=0, err_count+1 saturating):
  - err_code=1: on && off.
  - err_code=2: inc && dec.
  - err_code=3: channel >= NUM_CH.
- Legal command on channel c (cmd_done=1, cmd_ch=c):
  - power_on[c]: set by on, cleared by off, unchanged when neither is set.
  - increase[c]/decrease[c]/send[c]/receive[c]: pulse for one cycle per their flags.
  - amount, AMOUNT_MODE=0: amount[c] loads the field on every legal command.
  - amount, AMOUNT_MODE=1:
    - inc: amount[c] = min(amount[c] + field, 2**AMOUNT_WIDTH - 1).
    - dec: amount[c] = max(amount[c] - field, 0).
    - Neither: amount[c] unchanged.
  - Arithmetic uses AMOUNT_WIDTH+1 bits internally before clamping.
  - Other channels are untouched.
- Strobes, cmd_done and err are 0 on every cycle without a decode, including while hold=1.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.

Test Plan:
- Reset, then push 0x00000045 (on, ch1, amount 0) with hold=0 -> next edge power_on=4'b0010, cmd_done=1, cmd_ch=1, err=0.
- AMOUNT_MODE=1: ch0 amount=250; push inc with field 10 -> amount[0]=255; push dec with field 0x14 -> amount[0]=235; push dec with field 0xFF -> amount[0]=0.
- hold=1 with 5 back-to-back pushes (FIFO_DEPTH=4) -> 4 accepted, s_ready=0 on 5th, fifo_level=4; release hold -> 4 consecutive cmd_done pulses in push order, s_ready returns 1 after first pop.
- Push words with flags on+off, inc+dec, and ch=3 with NUM_CH=3 -> err pulses with err_code 1, 2, 3; err_count=3; power_on/amount unchanged. Then 260 illegal words -> err_count=255.
- Push send+receive on ch2 -> send=4'b0100 and receive=4'b0100 for exactly one cycle, then 0.
- Assert rst_n low with 3 entries queued and power_on=4'b1111 -> all outputs 0 immediately, fifo_level=0; after release no stale cmd_done.
